// File: rtl/age_ordered_reserve_station.sv
`default_nettype none
// ============================================================================
// Module      : age_ordered_reserve_station
// Description : Arithmetic reservation station. Holds RS_DEPTH waiting ops,
//               wakes operands from NUM_CDB broadcast buses and issues the
//               oldest ready op through a registered valid/ready output stage.
//               Optional macro RS_PERF_CNT_EN enables occupancy and
//               full-cycle performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module age_ordered_reserve_station #(
    parameter int RS_DEPTH = 16,
    parameter int ROB_ID_W = 4,
    parameter int DATA_W   = 32,
    parameter int OPENUM_W = 6,
    parameter int NUM_CDB  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         misbranch_flag,
    input  logic                         disp_en_i,
    input  logic [OPENUM_W-1:0]          disp_op_i,
    input  logic [ROB_ID_W-1:0]          disp_q1_i,
    input  logic [ROB_ID_W-1:0]          disp_q2_i,
    input  logic [DATA_W-1:0]            disp_v1_i,
    input  logic [DATA_W-1:0]            disp_v2_i,
    input  logic [DATA_W-1:0]            disp_imm_i,
    input  logic [DATA_W-1:0]            disp_pc_i,
    input  logic [ROB_ID_W-1:0]          disp_rob_i,
    output logic                         full_o,
    input  logic [NUM_CDB-1:0]           cdb_valid_i,
    input  logic [NUM_CDB*ROB_ID_W-1:0]  cdb_rob_i,
    input  logic [NUM_CDB*DATA_W-1:0]    cdb_data_i,
    output logic                         iss_valid_o,
    input  logic                         iss_ready_i,
    output logic [OPENUM_W-1:0]          iss_op_o,
    output logic [DATA_W-1:0]            iss_v1_o,
    output logic [DATA_W-1:0]            iss_v2_o,
    output logic [DATA_W-1:0]            iss_imm_o,
    output logic [DATA_W-1:0]            iss_pc_o,
    output logic [ROB_ID_W-1:0]          iss_rob_o,
    output logic [$clog2(RS_DEPTH):0]    occupancy_o,
    output logic [31:0]                  full_cycles_o
);

    localparam int c_IDX_W = $clog2(RS_DEPTH);
    localparam int c_CNT_W = c_IDX_W + 1;

    // Entry state; r_older[i][j]=1 means entry i was allocated before entry j
    logic [RS_DEPTH-1:0] r_busy;
    logic [OPENUM_W-1:0] r_op   [RS_DEPTH];
    logic [ROB_ID_W-1:0] r_q1   [RS_DEPTH];
    logic [ROB_ID_W-1:0] r_q2   [RS_DEPTH];
    logic [DATA_W-1:0]   r_v1   [RS_DEPTH];
    logic [DATA_W-1:0]   r_v2   [RS_DEPTH];
    logic [DATA_W-1:0]   r_imm  [RS_DEPTH];
    logic [DATA_W-1:0]   r_pc   [RS_DEPTH];
    logic [ROB_ID_W-1:0] r_rob  [RS_DEPTH];
    logic [RS_DEPTH-1:0] r_older[RS_DEPTH];

    logic                r_iss_valid;
    logic [OPENUM_W-1:0] r_iss_op;
    logic [DATA_W-1:0]   r_iss_v1, r_iss_v2, r_iss_imm, r_iss_pc;
    logic [ROB_ID_W-1:0] r_iss_rob;

    logic [ROB_ID_W-1:0] w_q1_nx[RS_DEPTH];
    logic [ROB_ID_W-1:0] w_q2_nx[RS_DEPTH];
    logic [DATA_W-1:0]   w_v1_nx[RS_DEPTH];
    logic [DATA_W-1:0]   w_v2_nx[RS_DEPTH];
    logic [ROB_ID_W-1:0] w_dq1, w_dq2;
    logic [DATA_W-1:0]   w_dv1, w_dv2;
    logic [RS_DEPTH-1:0] w_ready, w_blocked, w_sel_vec, w_busy_nx;
    logic [c_IDX_W-1:0]  w_alloc_idx, w_sel_idx;
    logic                w_full, w_alloc, w_sel_any, w_load, w_issue;

    assign w_full    = &r_busy;
    assign full_o    = w_full;
    assign w_alloc   = disp_en_i && !w_full;
    assign w_load    = !r_iss_valid || iss_ready_i;
    assign w_sel_any = |w_ready;
    assign w_issue   = w_load && w_sel_any;

    // Operand wakeup for stored entries and bypass for the dispatching op;
    // ports are scanned high-to-low so the lowest matching port wins
    always_comb begin
        w_dq1 = disp_q1_i;
        w_dq2 = disp_q2_i;
        w_dv1 = disp_v1_i;
        w_dv2 = disp_v2_i;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_q1_nx[i] = r_q1[i];
            w_q2_nx[i] = r_q2[i];
            w_v1_nx[i] = r_v1[i];
            w_v2_nx[i] = r_v2[i];
        end
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid_i[k]) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (r_q1[i] != '0 && r_q1[i] == cdb_rob_i[k*ROB_ID_W +: ROB_ID_W]) begin
                        w_q1_nx[i] = '0;
                        w_v1_nx[i] = cdb_data_i[k*DATA_W +: DATA_W];
                    end
                    if (r_q2[i] != '0 && r_q2[i] == cdb_rob_i[k*ROB_ID_W +: ROB_ID_W]) begin
                        w_q2_nx[i] = '0;
                        w_v2_nx[i] = cdb_data_i[k*DATA_W +: DATA_W];
                    end
                end
                if (disp_q1_i != '0 && disp_q1_i == cdb_rob_i[k*ROB_ID_W +: ROB_ID_W]) begin
                    w_dq1 = '0;
                    w_dv1 = cdb_data_i[k*DATA_W +: DATA_W];
                end
                if (disp_q2_i != '0 && disp_q2_i == cdb_rob_i[k*ROB_ID_W +: ROB_ID_W]) begin
                    w_dq2 = '0;
                    w_dv2 = cdb_data_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Lowest free slot for allocation and oldest ready entry for issue
    always_comb begin
        w_alloc_idx = '0;
        w_sel_idx   = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_alloc_idx = c_IDX_W'(i);
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_ready[i]   = r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_blocked[i] = 1'b0;
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (w_ready[j] && r_older[j][i]) w_blocked[i] = 1'b1;
            end
            w_sel_vec[i] = w_ready[i] && !w_blocked[i];
            if (w_sel_vec[i]) w_sel_idx = c_IDX_W'(i);
        end
    end

    // Next busy vector: flush clears, otherwise issue frees and dispatch sets
    always_comb begin
        w_busy_nx = r_busy;
        if (misbranch_flag) begin
            w_busy_nx = '0;
        end else if (rdy) begin
            if (w_issue) w_busy_nx[w_sel_idx]   = 1'b0;
            if (w_alloc) w_busy_nx[w_alloc_idx] = 1'b1;
        end
    end

    // Busy flags and registered issue stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy      <= '0;
            r_iss_valid <= 1'b0;
            r_iss_op    <= '0;
            r_iss_v1    <= '0;
            r_iss_v2    <= '0;
            r_iss_imm   <= '0;
            r_iss_pc    <= '0;
            r_iss_rob   <= '0;
        end else if (misbranch_flag) begin
            r_busy      <= '0;
            r_iss_valid <= 1'b0;
            r_iss_op    <= '0;
            r_iss_v1    <= '0;
            r_iss_v2    <= '0;
            r_iss_imm   <= '0;
            r_iss_pc    <= '0;
            r_iss_rob   <= '0;
        end else begin
            r_busy <= w_busy_nx;
            if (rdy && w_load) begin
                if (w_sel_any) begin
                    r_iss_valid <= 1'b1;
                    r_iss_op    <= r_op[w_sel_idx];
                    r_iss_v1    <= r_v1[w_sel_idx];
                    r_iss_v2    <= r_v2[w_sel_idx];
                    r_iss_imm   <= r_imm[w_sel_idx];
                    r_iss_pc    <= r_pc[w_sel_idx];
                    r_iss_rob   <= r_rob[w_sel_idx];
                end else begin
                    r_iss_valid <= 1'b0;
                end
            end
        end
    end

    // Entry payload and age matrix; only meaningful while busy, so no reset
    always_ff @(posedge clk) begin
        if (rdy && !misbranch_flag) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_q1[i] <= w_q1_nx[i];
                r_q2[i] <= w_q2_nx[i];
                r_v1[i] <= w_v1_nx[i];
                r_v2[i] <= w_v2_nx[i];
            end
            if (w_alloc) begin
                r_op [w_alloc_idx] <= disp_op_i;
                r_q1 [w_alloc_idx] <= w_dq1;
                r_q2 [w_alloc_idx] <= w_dq2;
                r_v1 [w_alloc_idx] <= w_dv1;
                r_v2 [w_alloc_idx] <= w_dv2;
                r_imm[w_alloc_idx] <= disp_imm_i;
                r_pc [w_alloc_idx] <= disp_pc_i;
                r_rob[w_alloc_idx] <= disp_rob_i;
                for (int j = 0; j < RS_DEPTH; j++) begin
                    r_older[j][w_alloc_idx] <= 1'b1;
                end
                r_older[w_alloc_idx] <= '0;
            end
        end
    end

    assign iss_valid_o = r_iss_valid;
    assign iss_op_o    = r_iss_op;
    assign iss_v1_o    = r_iss_v1;
    assign iss_v2_o    = r_iss_v2;
    assign iss_imm_o   = r_iss_imm;
    assign iss_pc_o    = r_iss_pc;
    assign iss_rob_o   = r_iss_rob;

`ifdef RS_PERF_CNT_EN
    logic [c_CNT_W-1:0] r_occupancy;
    logic [c_CNT_W-1:0] w_pop;
    logic [31:0]        r_full_cycles;

    // Population count of the next busy vector keeps occupancy aligned with busy
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_pop = w_pop + c_CNT_W'(w_busy_nx[i]);
        end
    end

    // Occupancy register and saturating full-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occupancy   <= '0;
            r_full_cycles <= '0;
        end else begin
            r_occupancy <= w_pop;
            if (rdy && w_full && r_full_cycles != 32'hFFFF_FFFF) begin
                r_full_cycles <= r_full_cycles + 32'd1;
            end
        end
    end

    assign occupancy_o   = r_occupancy;
    assign full_cycles_o = r_full_cycles;
`else
    assign occupancy_o   = '0;
    assign full_cycles_o = '0;
`endif

endmodule
`default_nettype wire
